fetch_unit: RTL and testbench

Instruction-fetch stage of the mycpu core: holds the program counter (PC) and instruction register (IR) and fetches 16-bit instruction words over a request/acknowledge instruction-memory port. It sits directly upstream of the control unit. It consumes the control unit's `il` (instruction load) and `ps` (PC select) outputs, and feeds the control unit's `ins` input from IR. `stall_out` lets the top level freeze the control-unit state register while a fetch is outstanding.

---
 rtl/mycpu_pkg.sv | 27 ++
 rtl/pc_next.sv | 35 +++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared definitions for the mycpu front end.
//   fetch_state_t   - fetch FSM state encoding (IDLE, WAIT)
//   PS_*            - PC-select encodings driven by the control unit
//   INS_W           - instruction word width
//   BOFF_*          - bit positions of the 6-bit branch offset {IR[8:6], IR[2:0]}
package mycpu_pkg;

    localparam int unsigned INS_W = 16;

    // Fetch FSM states kept as plain constants for compatibility with older tools.
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t IDLE = 1'b0;
    localparam fetch_state_t WAIT = 1'b1;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BRA  = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    // Branch offset is split across two IR fields: high part IR[8:6], low part IR[2:0].
    localparam int unsigned BOFF_HI_MSB = 8;
    localparam int unsigned BOFF_HI_LSB = 6;
    localparam int unsigned BOFF_LO_MSB = 2;
    localparam int unsigned BOFF_LO_LSB = 0;
    localparam int unsigned BOFF_W      = 6;

endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC computation.
//   pc          in  PC_W    current PC
//   ps          in  2       PC select (hold / increment / branch / jump)
//   boff        in  BOFF_W  raw branch offset, two's complement
//   jmp_target  in  PC_W    absolute jump target
//   pc_nxt      out PC_W    selected next PC (modulo 2^PC_W)
module pc_next
    import mycpu_pkg::*;
#(
    parameter int unsigned PC_W = 16
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [1:0]        ps,
    input  logic [BOFF_W-1:0] boff,
    input  logic [PC_W-1:0]   jmp_target,
    output logic [PC_W-1:0]   pc_nxt
);

    logic [PC_W-1:0] boff_ext;

    assign boff_ext = {{(PC_W - BOFF_W){boff[BOFF_W-1]}}, boff};

    // Additions drop the carry, so wrap-around is silent.
    always_comb begin
        pc_nxt = pc;
        unique case (ps)
            PS_HOLD: pc_nxt = pc;
            PS_INC:  pc_nxt = pc + PC_W'(1);
            PS_BRA:  pc_nxt = pc + boff_ext;
            PS_JMP:  pc_nxt = jmp_target;
            default: pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage holding PC and IR.
//   clk, rst_n      clock, asynchronous active-low reset
//   il_in           instruction-load request from the control unit
//   ps_in           PC select (00 hold, 01 inc, 10 branch, 11 jump)
//   a_in            jump target from register-file bus A
//   ins_out         IR contents
//   pc_out          current PC
//   stall_out       fetch outstanding; control unit freezes while high
//   imem_req_out    instruction-memory request
//   imem_addr_out   fetch address (always the PC)
//   imem_rdata_in   instruction word, valid with ack
//   imem_ack_in     single-cycle memory acknowledge
//   fetch_err_out   sticky fetch-timeout flag
// Build option: define MYCPU_FETCH_TIMEOUT_EN to abort a fetch that waits
// TIMEOUT_CYC cycles without an ack; otherwise WAIT persists indefinitely.
module fetch_unit
    import mycpu_pkg::*;
#(
    parameter int unsigned     PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             il_in,
    input  logic [1:0]       ps_in,
    input  logic [PC_W-1:0]  a_in,
    output logic [INS_W-1:0] ins_out,
    output logic [PC_W-1:0]  pc_out,
    output logic             stall_out,
    output logic             imem_req_out,
    output logic [PC_W-1:0]  imem_addr_out,
    input  logic [INS_W-1:0] imem_rdata_in,
    input  logic             imem_ack_in,
    output logic             fetch_err_out
);

    fetch_state_t     state_q, state_d;
    logic [INS_W-1:0] ir_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_nxt;
    logic [BOFF_W-1:0] boff;
    logic             ir_load;
    logic             timeout;

    assign boff = {ir_q[BOFF_HI_MSB:BOFF_HI_LSB], ir_q[BOFF_LO_MSB:BOFF_LO_LSB]};

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .pc         (pc_q),
        .ps         (ps_in),
        .boff       (boff),
        .jmp_target (a_in),
        .pc_nxt     (pc_nxt)
    );

`ifdef MYCPU_FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;
    logic             timeout_hit;

    // Fires on the last permitted WAIT cycle when the ack still has not come.
    assign timeout_hit = (state_q == WAIT) && !imem_ack_in &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counter sits at zero in IDLE, so it starts cleared on every WAIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + CNT_W'(1) : '0;
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign fetch_err_out = err_q;
`else
    logic timeout_hit;
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign fetch_err_out      = 1'b0;
`endif

    // Request and stall are combinational so a zero-wait fetch never stalls.
    always_comb begin
        state_d      = state_q;
        stall_out    = 1'b0;
        ir_load      = 1'b0;
        timeout      = 1'b0;
        imem_req_out = 1'b0;
        case (state_q)
            IDLE: begin
                imem_req_out = il_in;
                if (il_in) begin
                    if (imem_ack_in) begin
                        ir_load = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                imem_req_out = 1'b1;
                stall_out    = !imem_ack_in;
                if (imem_ack_in) begin
                    ir_load = 1'b1;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                ir_q <= imem_rdata_in;
            end else if (timeout) begin
                ir_q <= '0;
            end
            if (!stall_out) begin
                pc_q <= pc_nxt;
            end
        end
    end

    assign ins_out       = ir_q;
    assign pc_out        = pc_q;
    assign imem_addr_out = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        il_in;
    logic [1:0]  ps_in;
    logic [15:0] a_in;
    logic [15:0] ins_out;
    logic [15:0] pc_out;
    logic        stall_out;
    logic        imem_req_out;
    logic [15:0] imem_addr_out;
    logic [15:0] imem_rdata_in;
    logic        imem_ack_in;
    logic        fetch_err_out;

    int total;
    int bad;

    fetch_unit #(
        .PC_W        (16),
        .RESET_PC    (16'h0000),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .il_in         (il_in),
        .ps_in         (ps_in),
        .a_in          (a_in),
        .ins_out       (ins_out),
        .pc_out        (pc_out),
        .stall_out     (stall_out),
        .imem_req_out  (imem_req_out),
        .imem_addr_out (imem_addr_out),
        .imem_rdata_in (imem_rdata_in),
        .imem_ack_in   (imem_ack_in),
        .fetch_err_out (fetch_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        il_in         = 1'b0;
        ps_in         = 2'b00;
        a_in          = 16'h0000;
        imem_rdata_in = 16'h0000;
        imem_ack_in   = 1'b0;

        // Reset state
        #12;
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_ir", ins_out, 16'h0000);
        chk("rst_stall", stall_out, 0);
        chk("rst_req", imem_req_out, 0);
        chk("rst_err", fetch_err_out, 0);
        chk("rst_addr", imem_addr_out, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: zero-wait fetch
        il_in = 1'b1; imem_ack_in = 1'b1; imem_rdata_in = 16'h1234;
        #1;
        chk("t1_stall", stall_out, 0);
        chk("t1_req", imem_req_out, 1);
        tick();
        il_in = 1'b0; imem_ack_in = 1'b0;
        #1;
        chk("t1_ir", ins_out, 16'h1234);
        chk("t1_pc", pc_out, 16'h0000);
        chk("t1_stall_after", stall_out, 0);

        // 2: ack three cycles late; ps=01 during stall must not move PC
        il_in = 1'b1; ps_in = 2'b01; imem_rdata_in = 16'h5678;
        #1;
        chk("t2_stall_c0", stall_out, 1);
        chk("t2_addr_c0", imem_addr_out, 16'h0000);
        tick();
        il_in = 1'b0;
        #1;
        chk("t2_stall_c1", stall_out, 1);
        chk("t2_req_c1", imem_req_out, 1);
        chk("t2_addr_c1", imem_addr_out, 16'h0000);
        chk("t2_ir_c1", ins_out, 16'h1234);
        tick();
        chk("t2_stall_c2", stall_out, 1);
        chk("t2_pc_c2", pc_out, 16'h0000);
        tick();
        ps_in = 2'b00; imem_ack_in = 1'b1;
        #1;
        chk("t2_stall_ack", stall_out, 0);
        chk("t2_addr_ack", imem_addr_out, 16'h0000);
        tick();
        imem_ack_in = 1'b0;
        #1;
        chk("t2_ir", ins_out, 16'h5678);
        chk("t2_pc", pc_out, 16'h0000);
        chk("t2_stall_done", stall_out, 0);
        chk("t2_req_done", imem_req_out, 0);

        // 3: fetch IR=01C6 (offset -2) while jumping to 0010, then branch
        il_in = 1'b1; imem_ack_in = 1'b1; imem_rdata_in = 16'h01C6;
        ps_in = 2'b11; a_in = 16'h0010;
        tick();
        il_in = 1'b0; imem_ack_in = 1'b0; ps_in = 2'b00;
        #1;
        chk("t3_ir_neg", ins_out, 16'h01C6);
        chk("t3_pc_jmp", pc_out, 16'h0010);
        ps_in = 2'b10;
        tick();
        ps_in = 2'b00;
        #1;
        chk("t3_bra_neg", pc_out, 16'h000E);
        // IR=00C7 gives offset +31; jump to FFF0 in the same cycle
        il_in = 1'b1; imem_ack_in = 1'b1; imem_rdata_in = 16'h00C7;
        ps_in = 2'b11; a_in = 16'hFFF0;
        #1;
        chk("t3_addr_oldpc", imem_addr_out, 16'h000E);
        tick();
        il_in = 1'b0; imem_ack_in = 1'b0; ps_in = 2'b10;
        #1;
        chk("t3_ir_pos", ins_out, 16'h00C7);
        chk("t3_pc_fff0", pc_out, 16'hFFF0);
        tick();
        ps_in = 2'b00;
        #1;
        chk("t3_bra_wrap", pc_out, 16'h000F);

        // 4: jump, increment wrap, hold
        ps_in = 2'b11; a_in = 16'hBEEF;
        tick();
        chk("t4_jmp", pc_out, 16'hBEEF);
        a_in = 16'hFFFF;
        tick();
        ps_in = 2'b01;
        tick();
        chk("t4_inc_wrap", pc_out, 16'h0000);
        ps_in = 2'b00;
        // stray ack in IDLE without il is ignored
        imem_ack_in = 1'b1; imem_rdata_in = 16'hDEAD;
        #1;
        chk("t4_req_idle", imem_req_out, 0);
        tick();
        imem_ack_in = 1'b0;
        #1;
        chk("t4_hold", pc_out, 16'h0000);
        chk("t4_ir_ignored", ins_out, 16'h00C7);

        // 5: reset during WAIT
        ps_in = 2'b11; a_in = 16'h0040;
        tick();
        ps_in = 2'b00; il_in = 1'b1;
        tick();
        il_in = 1'b0;
        #1;
        chk("t5_stall_wait", stall_out, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_req_rst", imem_req_out, 0);
        chk("t5_stall_rst", stall_out, 0);
        chk("t5_pc_rst", pc_out, 16'h0000);
        chk("t5_ir_rst", ins_out, 16'h0000);
        tick();
        rst_n = 1'b1; imem_ack_in = 1'b1; imem_rdata_in = 16'hBBBB;
        tick();
        imem_ack_in = 1'b0;
        #1;
        chk("t5_late_ack", ins_out, 16'h0000);
        chk("t5_req_after", imem_req_out, 0);

        // 6: no ack at all
        ps_in = 2'b01; il_in = 1'b1;
        tick();
        il_in = 1'b0;
`ifdef MYCPU_FETCH_TIMEOUT_EN
        repeat (4) tick();
        chk("t6_err", fetch_err_out, 1);
        chk("t6_ir", ins_out, 16'h0000);
        chk("t6_stall", stall_out, 0);
        chk("t6_pc", pc_out, 16'h0000);
        ps_in = 2'b00;
        repeat (3) tick();
        chk("t6_err_sticky", fetch_err_out, 1);
`else
        repeat (100) tick();
        chk("t6_stall", stall_out, 1);
        chk("t6_req", imem_req_out, 1);
        chk("t6_err", fetch_err_out, 0);
        chk("t6_pc", pc_out, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
